// File: rtl/video_pkg.sv
// video_pkg: shared widths, accumulator reload constant and RGB channel slicing.
package video_pkg;
    localparam int PIX_W = 24;
    localparam int COORD_W = 12;
    localparam logic [COORD_W-1:0] COORD_MAX = 12'hFFF;

    // Channel 0 = B, 1 = G, 2 = R.
    function automatic logic [7:0] chan(input logic [PIX_W-1:0] p, input int i);
        return p[8*i +: 8];
    endfunction
endpackage

// File: rtl/video_bbox_overlay_cmp.sv
// rgb_window_cmp: inclusive per-channel unsigned window test on one RGB888 pixel.
module rgb_window_cmp
    import video_pkg::*;
(
    input  logic [PIX_W-1:0] pix_i,
    input  logic [PIX_W-1:0] lo_i,
    input  logic [PIX_W-1:0] hi_i,
    output logic             hit_o
);
    logic [2:0] ok;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        assign ok[c] = chan(lo_i, c) <= chan(pix_i, c) && chan(pix_i, c) <= chan(hi_i, c);
    end

    assign hit_o = &ok;
endmodule

// File: rtl/video_bbox_overlay.sv
// video_bbox_overlay: per-frame colour-window bounding box with previous-frame border overlay.
module video_bbox_overlay
    import video_pkg::*;
#(
    parameter int unsigned      BORDER    = 2,
    parameter logic [PIX_W-1:0] BOX_COLOR = 24'hFF0000,
    parameter int unsigned      MIN_HITS  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic               i_de,
    input  logic [PIX_W-1:0]   i_data,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [PIX_W-1:0]   th_lo,
    input  logic [PIX_W-1:0]   th_hi,
    input  logic               overlay_en,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic [PIX_W-1:0]   o_data,
    output logic [COORD_W-1:0] box_x_min,
    output logic [COORD_W-1:0] box_x_max,
    output logic [COORD_W-1:0] box_y_min,
    output logic [COORD_W-1:0] box_y_max,
    output logic               box_valid,
    output logic [19:0]        hit_count,
    output logic               frame_done
);
    localparam logic [COORD_W:0] B13 = (COORD_W+1)'(BORDER);

    logic               hs1_q, vs1_q, de1_q, hit1_q, hit, fs, border, ov_en_q;
    logic [PIX_W-1:0]   data1_q, lo_q, hi_q;
    logic [COORD_W-1:0] x1_q, y1_q;
    logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q, xmin_d, xmax_d, ymin_d, ymax_d;
    logic [19:0]        cnt_q, cnt_d;
    logic [COORD_W:0]   x13, y13, bx0, bx1, by0, by1;

    assign fs = i_vs & ~vs1_q;

    rgb_window_cmp u_cmp (.pix_i(i_data), .lo_i(lo_q), .hi_i(hi_q), .hit_o(hit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {hs1_q, vs1_q, de1_q, hit1_q, data1_q, x1_q, y1_q} <= '0;
        else     {hs1_q, vs1_q, de1_q, hit1_q, data1_q, x1_q, y1_q} <= {i_hs, i_vs, i_de, i_de & hit, i_data, i_x, i_y};
    end

    // Frame-start reload wins over a stage-1 hit landing on the same edge.
    always_comb begin
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        cnt_d  = cnt_q;
        if (fs) begin
            {xmin_d, xmax_d, ymin_d, ymax_d, cnt_d} = {COORD_MAX, {COORD_W{1'b0}}, COORD_MAX, {COORD_W{1'b0}}, 20'd0};
        end else if (hit1_q) begin
            xmin_d = x1_q < xmin_q ? x1_q : xmin_q;
            xmax_d = x1_q > xmax_q ? x1_q : xmax_q;
            ymin_d = y1_q < ymin_q ? y1_q : ymin_q;
            ymax_d = y1_q > ymax_q ? y1_q : ymax_q;
            cnt_d  = cnt_q + {19'd0, ~&cnt_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {xmin_q, xmax_q, ymin_q, ymax_q, cnt_q} <= {COORD_MAX, {COORD_W{1'b0}}, COORD_MAX, {COORD_W{1'b0}}, 20'd0};
            {lo_q, hi_q, ov_en_q} <= '0;
            {box_x_min, box_x_max, box_y_min, box_y_max, box_valid, hit_count, frame_done} <= '0;
        end else begin
            {xmin_q, xmax_q, ymin_q, ymax_q, cnt_q} <= {xmin_d, xmax_d, ymin_d, ymax_d, cnt_d};
            frame_done <= fs;
            if (fs) begin
                {box_x_min, box_x_max, box_y_min, box_y_max} <= {xmin_q, xmax_q, ymin_q, ymax_q};
                box_valid <= cnt_q >= 20'(MIN_HITS);
                hit_count <= cnt_q;
                {lo_q, hi_q, ov_en_q} <= {th_lo, th_hi, overlay_en};
            end
        end
    end

    // 13-bit edges keep the border band from wrapping near 0 and 4095.
    assign x13 = {1'b0, x1_q};
    assign y13 = {1'b0, y1_q};
    assign bx0 = {1'b0, box_x_min};
    assign bx1 = {1'b0, box_x_max};
    assign by0 = {1'b0, box_y_min};
    assign by1 = {1'b0, box_y_max};
    assign border = ov_en_q & box_valid & de1_q
                  & x13 >= bx0 & x13 <= bx1 & y13 >= by0 & y13 <= by1
                  & (x13 < bx0 + B13 | x13 > bx1 - B13 | y13 < by0 + B13 | y13 > by1 - B13);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {o_hs, o_vs, o_de, o_data} <= '0;
        else     {o_hs, o_vs, o_de, o_data} <= {hs1_q, vs1_q, de1_q, border ? BOX_COLOR : data1_q};
    end
endmodule
